// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed Booth multiplier with start/done handshake.
// Default build uses radix-2 recoding: N iterations, N+1 edges from start to done.
// Define BOOTH_RADIX4_EN for modified Booth radix-4: ceil(N/2) iterations, ceil(N/2)+1 edges.
// The product register only changes in FINISH, so it never exposes partial sums.

module booth_multiplier #(
   parameter int N = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [N-1:0]          multiplicand,
   input  logic [N-1:0]          multiplier,
   output logic signed [2*N-1:0] product,
   output logic                  done
);

`ifdef BOOTH_RADIX4_EN
   // Radix-4: two multiplier bits retired per iteration; the accumulator carries
   // two guard bits so that +-2A never overflows, and an odd-width multiplier
   // is sign-extended to an even width.
   localparam int ITER = (N + 1) / 2;
   localparam int AW   = N + 2;
   localparam int QW   = 2 * ITER;
   localparam int SH   = 2;
`else
   // Radix-2: one multiplier bit retired per iteration; a single guard bit in the
   // accumulator covers subtracting the most negative multiplicand.
   localparam int ITER = N;
   localparam int AW   = N + 1;
   localparam int QW   = N;
   localparam int SH   = 1;
`endif

   localparam int CW = (ITER < 2) ? 1 : $clog2(ITER);
   localparam int WW = AW + QW + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [N-1:0]        a_reg;
   logic [AW-1:0]       acc;
   logic [QW-1:0]       q;
   logic                q_m1;
   logic [CW-1:0]       count;
   logic                accept;
   logic                last_iter;
   logic signed [AW-1:0] a_ext;
   logic [AW-1:0]       addend;
   logic [AW-1:0]       sum;
   logic signed [WW-1:0] shifted;

   assign accept    = start && !done;
   assign last_iter = (count == CW'(ITER - 1));
   assign a_ext     = AW'($signed(a_reg));

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: start is only honoured in IDLE and not while done is still high.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = CALC;
         CALC:    if (last_iter) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef BOOTH_RADIX4_EN
   // Booth radix-4 recoding of {Q1,Q0,Q-1} into 0, +-A or +-2A.
   always_comb begin
      addend = '0;
      case ({q[1], q[0], q_m1})
         3'b001, 3'b010: addend = a_ext;
         3'b011:         addend = {a_ext[AW-2:0], 1'b0};
         3'b100:         addend = -{a_ext[AW-2:0], 1'b0};
         3'b101, 3'b110: addend = -a_ext;
         default:        addend = '0;
      endcase
   end
`else
   // Booth radix-2 recoding of {Q0,Q-1} into 0 or +-A.
   always_comb begin
      addend = '0;
      case ({q[0], q_m1})
         2'b01:   addend = a_ext;
         2'b10:   addend = -a_ext;
         default: addend = '0;
      endcase
   end
`endif

   // One iteration: add the recoded partial product, then arithmetic-shift the whole
   // {acc, Q, Q-1} register right so the sign of the accumulator is preserved.
   always_comb begin
      sum     = acc + addend;
      shifted = $signed({sum, q, q_m1}) >>> SH;
   end

   // Datapath registers: operand capture, iteration and result publication.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a_reg   <= '0;
         acc     <= '0;
         q       <= '0;
         q_m1    <= 1'b0;
         count   <= '0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  a_reg <= multiplicand;
                  acc   <= '0;
                  q     <= QW'($signed(multiplier));
                  q_m1  <= 1'b0;
                  count <= '0;
               end
            end
            CALC: begin
               acc   <= shifted[WW-1:QW+1];
               q     <= shifted[QW:1];
               q_m1  <= shifted[0];
               count <= count + 1'b1;
            end
            FINISH: begin
               product <= (2*N)'({acc, q});
               done    <= 1'b1;
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: randomized and directed checks of booth_multiplier against
// plain signed multiplication. Latency expectation follows BOOTH_RADIX4_EN.

module tb_booth_multiplier;

   localparam int N = 4;
`ifdef BOOTH_RADIX4_EN
   localparam int LAT = (N + 1) / 2 + 1;
`else
   localparam int LAT = N + 1;
`endif

   logic                  clock;
   logic                  reset;
   logic                  start;
   logic [N-1:0]          multiplicand;
   logic [N-1:0]          multiplier;
   logic signed [2*N-1:0] product;
   logic                  done;

   int errors = 0;
   int checks = 0;

   booth_multiplier #(.N(N)) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .multiplicand(multiplicand),
      .multiplier(multiplier),
      .product(product),
      .done(done)
   );

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference: the exact signed product in 2N bits.
   function automatic logic signed [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      int ia;
      int ib;
      ia = $signed(a);
      ib = $signed(b);
      return (2*N)'(ia * ib);
   endfunction

   // Present a one-cycle start pulse; returns just after the accepting edge.
   task automatic pulse_start(input logic [N-1:0] a, input logic [N-1:0] b);
      @(posedge clock); #1;
      start = 1'b1;
      multiplicand = a;
      multiplier = b;
      @(posedge clock); #1;
      start = 1'b0;
      multiplicand = N'($urandom);
      multiplier = N'($urandom);
   endtask

   // Count edges until done is seen high; -1 if it never arrives within the budget.
   task automatic wait_done(output int edges);
      edges = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock); #1;
         if (done) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      start = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      #12;
      checks++;
      if (product !== '0) begin
         errors++;
         $display("[TB] FAIL reset_product got=%0d want=0", product);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_done got=%b want=0", done);
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_directed;
      logic [N-1:0] ta [6];
      logic [N-1:0] tb_ [6];
      logic signed [2*N-1:0] want [6];
      int edges;
      ta[0] = -4'sd5; tb_[0] = -4'sd3; want[0] = 8'sd15;
      ta[1] = -4'sd8; tb_[1] =  4'sd4; want[1] = -8'sd32;
      ta[2] = -4'sd8; tb_[2] =  4'sd7; want[2] = -8'sd56;
      ta[3] = -4'sd8; tb_[3] = -4'sd8; want[3] = 8'sd64;
      ta[4] =  4'sd0; tb_[4] = -4'sd8; want[4] = 8'sd0;
      ta[5] = -4'sd8; tb_[5] =  4'sd0; want[5] = 8'sd0;
      for (int i = 0; i < 6; i++) begin
         pulse_start(ta[i], tb_[i]);
         wait_done(edges);
         checks++;
         if (edges != LAT) begin
            errors++;
            $display("[TB] FAIL directed_latency case=%0d got=%0d want=%0d", i, edges, LAT);
         end
         checks++;
         if (product !== want[i]) begin
            errors++;
            $display("[TB] FAIL directed_product case=%0d got=%0d want=%0d", i, product, want[i]);
         end
         @(posedge clock); #1;
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL directed_done_width case=%0d got=%b want=0", i, done);
         end
      end
   endtask

   task automatic test_random;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic signed [2*N-1:0] prev;
      logic signed [2*N-1:0] want;
      int edges;
      bit stable;
      for (int i = 0; i < 40; i++) begin
         a = N'($urandom);
         b = N'($urandom);
         want = ref_mul(a, b);
         prev = product;
         pulse_start(a, b);
         edges = -1;
         stable = 1'b1;
         for (int e = 1; e <= 40; e++) begin
            @(posedge clock); #1;
            if (done) begin
               edges = e;
               break;
            end
            if (product !== prev) stable = 1'b0;
         end
         checks++;
         if (!stable) begin
            errors++;
            $display("[TB] FAIL random_product_stable a=%0d b=%0d got=changed want=%0d", $signed(a), $signed(b), prev);
         end
         checks++;
         if (edges != LAT) begin
            errors++;
            $display("[TB] FAIL random_latency a=%0d b=%0d got=%0d want=%0d", $signed(a), $signed(b), edges, LAT);
         end
         checks++;
         if (product !== want) begin
            errors++;
            $display("[TB] FAIL random_product a=%0d b=%0d got=%0d want=%0d", $signed(a), $signed(b), product, want);
         end
      end
   endtask

   task automatic test_start_ignored;
      int edges;
      logic signed [2*N-1:0] want;
      want = ref_mul(4'd3, 4'd5);
      pulse_start(4'd3, 4'd5);
      start = 1'b1;
      multiplicand = -4'sd7;
      multiplier = -4'sd6;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(edges);
      checks++;
      if (edges != LAT - 1) begin
         errors++;
         $display("[TB] FAIL busy_start_latency got=%0d want=%0d", edges, LAT - 1);
      end
      checks++;
      if (product !== want) begin
         errors++;
         $display("[TB] FAIL busy_start_product got=%0d want=%0d", product, want);
      end
      // Start presented while done is high must also be dropped.
      start = 1'b1;
      multiplicand = 4'd7;
      multiplier = 4'd7;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(edges);
      checks++;
      if (edges != -1) begin
         errors++;
         $display("[TB] FAIL done_start_ignored got=done_after_%0d want=no_done", edges);
      end
      checks++;
      if (product !== want) begin
         errors++;
         $display("[TB] FAIL done_start_product got=%0d want=%0d", product, want);
      end
   endtask

   task automatic test_back_to_back;
      int edges;
      logic signed [2*N-1:0] want;
      want = ref_mul(-4'sd2, 4'd6);
      pulse_start(-4'sd2, 4'd6);
      wait_done(edges);
      pulse_start(4'd7, -4'sd1);
      want = ref_mul(4'd7, -4'sd1);
      wait_done(edges);
      checks++;
      if (edges != LAT) begin
         errors++;
         $display("[TB] FAIL back_to_back_latency got=%0d want=%0d", edges, LAT);
      end
      checks++;
      if (product !== want) begin
         errors++;
         $display("[TB] FAIL back_to_back_product got=%0d want=%0d", product, want);
      end
   endtask

   task automatic test_reset_mid;
      int edges;
      logic signed [2*N-1:0] want;
      pulse_start(-4'sd5, 4'd7);
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      checks++;
      if (product !== '0) begin
         errors++;
         $display("[TB] FAIL mid_reset_product got=%0d want=0", product);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset_done got=%b want=0", done);
      end
      @(negedge clock);
      reset = 1'b1;
      wait_done(edges);
      checks++;
      if (edges != -1) begin
         errors++;
         $display("[TB] FAIL mid_reset_no_done got=done_after_%0d want=no_done", edges);
      end
      want = ref_mul(-4'sd5, -4'sd3);
      pulse_start(-4'sd5, -4'sd3);
      wait_done(edges);
      checks++;
      if (edges != LAT || product !== want) begin
         errors++;
         $display("[TB] FAIL after_reset_op got=%0d@%0d want=%0d@%0d", product, edges, want, LAT);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_start_ignored;
      test_back_to_back;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
